// File: rtl/uart_pkg.sv
//==============================================================================
// Module : uart_pkg
// Brief  : Shared state encoding and default sizing for the UART receive path.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

package uart_pkg;

    localparam int c_DEFAULT_SIZE      = 32;
    localparam int c_DEFAULT_MAX_RETRY = 3;
    localparam int c_DEFAULT_TIMEOUT   = 64;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_WORD = 3'd1,
        S_RESEND    = 3'd2,
        S_HOLD      = 3'd3,
        S_ABORT     = 3'd4
    } rx_state_e;

    // Keeps counter widths legal when a parameter collapses to a single value.
    function automatic int safe_clog2(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rx_timeout_timer.sv
//==============================================================================
// Module : rx_timeout_timer
// Brief  : Saturating word timer; expired flags TIMEOUT-1 cycles of running.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rx_timeout_timer
    import uart_pkg::*;
#(
    parameter int TIMEOUT = c_DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int                TW     = safe_clog2(TIMEOUT);
    localparam logic [TW-1:0]     c_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= '0;
        end else if (run && (count_q != c_LAST)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired = (count_q == c_LAST);

endmodule

`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
//==============================================================================
// Module : uart_rx_ctrl
// Brief  : Receive-session controller: word capture, resend retries, abort.
//          Optional GoodCnt/ErrCnt statistics under UART_RX_CTRL_STATS_EN.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int size      = c_DEFAULT_SIZE,
    parameter int MAX_RETRY = c_DEFAULT_MAX_RETRY,
    parameter int TIMEOUT   = c_DEFAULT_TIMEOUT
) (
    input  logic                                  CLK_Baudin,
    input  logic                                  RstRx,
    input  logic                                  Enable,
    input  logic [size-1:0]                       RxData,
    input  logic                                  RxDone,
    input  logic                                  RxParityErr,
    output logic                                  RxEnable,
    output logic                                  ResendReq,
    output logic [size-1:0]                       DataOut,
    output logic                                  DataValid,
    input  logic                                  DataReady,
    output logic                                  ErrAbort,
    output logic [safe_clog2(MAX_RETRY+1)-1:0]    RetryCount
`ifdef UART_RX_CTRL_STATS_EN
    ,
    output logic [15:0]                           GoodCnt,
    output logic [15:0]                           ErrCnt
`endif
);

    localparam int            RW            = safe_clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] c_RETRY_LIMIT = RW'(MAX_RETRY);

    rx_state_e       state_q;
    logic            rx_enable_q;
    logic            resend_q;
    logic            valid_q;
    logic            abort_q;
    logic [size-1:0] data_q;
    logic [RW-1:0]   retry_q;

    logic w_fail;
    logic w_take;
    logic w_timer_clear;
    logic w_timer_run;
    logic w_timer_expired;

    // A parity error wins over a simultaneous RxDone: the word is suspect.
    assign w_fail        = RxParityErr || w_timer_expired;
    assign w_take        = (state_q == S_HOLD) && DataReady;
    assign w_timer_run   = (state_q == S_WAIT_WORD);
    assign w_timer_clear = (state_q == S_IDLE) || (state_q == S_RESEND) ||
                           (state_q == S_ABORT) || w_take;

    rx_timeout_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (CLK_Baudin),
        .rst     (RstRx),
        .clear   (w_timer_clear),
        .run     (w_timer_run),
        .expired (w_timer_expired)
    );

    always_ff @(posedge CLK_Baudin) begin
        if (RstRx) begin
            state_q     <= S_IDLE;
            rx_enable_q <= 1'b0;
            resend_q    <= 1'b0;
            valid_q     <= 1'b0;
            abort_q     <= 1'b0;
            data_q      <= '0;
            retry_q     <= '0;
        end else begin
            resend_q <= 1'b0;
            abort_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    rx_enable_q <= 1'b0;
                    retry_q     <= '0;
                    if (Enable) begin
                        state_q     <= S_WAIT_WORD;
                        rx_enable_q <= 1'b1;
                    end
                end
                S_WAIT_WORD: begin
                    if (!Enable) begin
                        state_q     <= S_IDLE;
                        rx_enable_q <= 1'b0;
                        retry_q     <= '0;
                    end else if (w_fail) begin
                        rx_enable_q <= 1'b0;
                        if (retry_q < c_RETRY_LIMIT) begin
                            retry_q  <= retry_q + 1'b1;
                            resend_q <= 1'b1;
                            state_q  <= S_RESEND;
                        end else begin
                            retry_q <= '0;
                            abort_q <= 1'b1;
                            state_q <= S_ABORT;
                        end
                    end else if (RxDone) begin
                        data_q      <= RxData;
                        valid_q     <= 1'b1;
                        rx_enable_q <= 1'b0;
                        state_q     <= S_HOLD;
                    end
                end
                S_RESEND: begin
                    if (Enable) begin
                        state_q     <= S_WAIT_WORD;
                        rx_enable_q <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        retry_q <= '0;
                    end
                end
                S_HOLD: begin
                    if (DataReady) begin
                        valid_q <= 1'b0;
                        retry_q <= '0;
                        if (Enable) begin
                            state_q     <= S_WAIT_WORD;
                            rx_enable_q <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_ABORT: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q     <= S_IDLE;
                    rx_enable_q <= 1'b0;
                end
            endcase
        end
    end

    assign RxEnable   = rx_enable_q;
    assign ResendReq  = resend_q;
    assign DataOut    = data_q;
    assign DataValid  = valid_q;
    assign ErrAbort   = abort_q;
    assign RetryCount = retry_q;

`ifdef UART_RX_CTRL_STATS_EN
    logic [15:0] good_q;
    logic [15:0] err_q;
    logic        w_fail_event;

    assign w_fail_event = (state_q == S_WAIT_WORD) && Enable && w_fail;

    always_ff @(posedge CLK_Baudin) begin
        if (RstRx) begin
            good_q <= '0;
            err_q  <= '0;
        end else begin
            if (w_take && (good_q != 16'hFFFF)) begin
                good_q <= good_q + 16'd1;
            end
            if (w_fail_event && (err_q != 16'hFFFF)) begin
                err_q <= err_q + 16'd1;
            end
        end
    end

    assign GoodCnt = good_q;
    assign ErrCnt  = err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
//==============================================================================
// Module : tb_uart_rx_ctrl
// Brief  : Directed self-checking bench for uart_rx_ctrl (default parameters).
//          Exercises GoodCnt/ErrCnt when UART_RX_CTRL_STATS_EN is defined.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_uart_rx_ctrl;

    logic        clk = 1'b0;
    logic        RstRx = 1'b1;
    logic        Enable = 1'b0;
    logic [31:0] RxData = '0;
    logic        RxDone = 1'b0;
    logic        RxParityErr = 1'b0;
    logic        DataReady = 1'b0;
    logic        RxEnable;
    logic        ResendReq;
    logic [31:0] DataOut;
    logic        DataValid;
    logic        ErrAbort;
    logic [1:0]  RetryCount;
`ifdef UART_RX_CTRL_STATS_EN
    logic [15:0] GoodCnt;
    logic [15:0] ErrCnt;
`endif

    int total = 0;
    int bad   = 0;
    int rs_total = 0;
    int ab_total = 0;
    int dv_total = 0;

    logic [31:0] exp_q[$];
    logic [31:0] last_word = '0;

    always #5 clk = ~clk;

    uart_rx_ctrl dut (
        .CLK_Baudin  (clk),
        .RstRx       (RstRx),
        .Enable      (Enable),
        .RxData      (RxData),
        .RxDone      (RxDone),
        .RxParityErr (RxParityErr),
        .RxEnable    (RxEnable),
        .ResendReq   (ResendReq),
        .DataOut     (DataOut),
        .DataValid   (DataValid),
        .DataReady   (DataReady),
        .ErrAbort    (ErrAbort),
        .RetryCount  (RetryCount)
`ifdef UART_RX_CTRL_STATS_EN
        ,
        .GoodCnt     (GoodCnt),
        .ErrCnt      (ErrCnt)
`endif
    );

    // Pulse counters sampled mid-cycle so single-cycle outputs are seen exactly once.
    always @(negedge clk) begin
        if (ResendReq) rs_total++;
        if (ErrAbort)  ab_total++;
        if (DataValid) dv_total++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        RxData = w;
        RxDone = 1'b1;
        exp_q.push_back(w);
        tick();
        RxDone = 1'b0;
        RxData = '0;
    endtask

    task automatic deliver(input string tag);
        int          n;
        logic [31:0] expw;
        n = 0;
        while (!DataValid && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 64'(DataValid), 64'd1);
        if (DataValid && exp_q.size() > 0) begin
            expw = exp_q.pop_front();
            chk({tag, "_data"}, 64'(DataOut), 64'(expw));
            last_word = expw;
        end
        DataReady = 1'b1;
        tick();
        DataReady = 1'b0;
        chk({tag, "_taken"}, 64'(DataValid), 64'd0);
    endtask

    initial begin
        int rs_base;
        int ab_base;
        int dv_base;
        int n;
        bit hold_ok;

        // Reset state
        tick();
        tick();
        RstRx = 1'b0;
        chk("rst_rxen",  64'(RxEnable),   64'd0);
        chk("rst_valid", 64'(DataValid),  64'd0);
        chk("rst_dout",  64'(DataOut),    64'd0);
        chk("rst_retry", 64'(RetryCount), 64'd0);
        chk("rst_abort", 64'(ErrAbort),   64'd0);

        // Clean word, one-cycle latency, return to WAIT_WORD
        Enable = 1'b1;
        tick();
        chk("s1_rxen_wait", 64'(RxEnable), 64'd1);
        send_word(32'hA5A5_5A5A);
        chk("s1_latency", 64'(DataValid), 64'd1);
        chk("s1_rxen_hold", 64'(RxEnable), 64'd0);
        deliver("s1");
        chk("s1_back_wait", 64'(RxEnable), 64'd1);

        // Two parity errors then a good word
        rs_base = rs_total;
        for (int i = 1; i <= 2; i++) begin
            RxParityErr = 1'b1;
            tick();
            RxParityErr = 1'b0;
            chk("s2_resend", 64'(ResendReq), 64'd1);
            chk("s2_retry", 64'(RetryCount), 64'(i));
            tick();
            chk("s2_resend_off", 64'(ResendReq), 64'd0);
        end
        send_word(32'h1234_5678);
        chk("s2_retry_hold", 64'(RetryCount), 64'd2);
        deliver("s2");
        chk("s2_retry_clr", 64'(RetryCount), 64'd0);
        chk("s2_resend_pulses", 64'(rs_total - rs_base), 64'd2);

        // Retries exhausted -> abort
        rs_base = rs_total;
        ab_base = ab_total;
        dv_base = dv_total;
        for (int i = 1; i <= 3; i++) begin
            RxParityErr = 1'b1;
            tick();
            RxParityErr = 1'b0;
            chk("s3_retry", 64'(RetryCount), 64'(i));
            tick();
        end
        RxParityErr = 1'b1;
        tick();
        RxParityErr = 1'b0;
        chk("s3_abort", 64'(ErrAbort), 64'd1);
        chk("s3_retry_clr", 64'(RetryCount), 64'd0);
        tick();
        chk("s3_abort_off", 64'(ErrAbort), 64'd0);
        chk("s3_idle_rxen", 64'(RxEnable), 64'd0);
        chk("s3_resend_pulses", 64'(rs_total - rs_base), 64'd3);
        chk("s3_abort_pulses", 64'(ab_total - ab_base), 64'd1);
        chk("s3_valid_never", 64'(dv_total - dv_base), 64'd0);
        tick();
        chk("s3_rewait", 64'(RxEnable), 64'd1);

        // Timeout after 64 WAIT_WORD cycles, then RxDone+RxParityErr together
        n = 0;
        while (!ResendReq && n < 100) begin
            tick();
            n++;
        end
        chk("s4_timeout_cycles", 64'(n), 64'd64);
        chk("s4_timeout_retry", 64'(RetryCount), 64'd1);
        tick();
        RxData = 32'hDEAD_BEEF;
        RxDone = 1'b1;
        RxParityErr = 1'b1;
        tick();
        RxDone = 1'b0;
        RxParityErr = 1'b0;
        chk("s4_both_resend", 64'(ResendReq), 64'd1);
        chk("s4_both_retry", 64'(RetryCount), 64'd2);
        chk("s4_both_valid", 64'(DataValid), 64'd0);
        chk("s4_both_dout", 64'(DataOut), 64'(last_word));
        tick();

        // Stalled HOLD overridden by reset
        send_word(32'hCAFE_F00D);
        chk("s5_valid", 64'(DataValid), 64'd1);
        hold_ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!(DataValid === 1'b1 && RxEnable === 1'b0 && DataOut === 32'hCAFE_F00D))
                hold_ok = 1'b0;
        end
        chk("s5_hold_stable", 64'(hold_ok), 64'd1);
`ifdef UART_RX_CTRL_STATS_EN
        chk("s5_good_pre", 64'(GoodCnt), 64'd2);
        chk("s5_err_pre", 64'(ErrCnt), 64'd8);
`endif
        RstRx = 1'b1;
        tick();
        RstRx = 1'b0;
        exp_q.delete();
        chk("s5_rst_valid", 64'(DataValid), 64'd0);
        chk("s5_rst_rxen", 64'(RxEnable), 64'd0);
        chk("s5_rst_dout", 64'(DataOut), 64'd0);
        chk("s5_rst_retry", 64'(RetryCount), 64'd0);
        chk("s5_rst_resend", 64'(ResendReq), 64'd0);
`ifdef UART_RX_CTRL_STATS_EN
        chk("s5_rst_good", 64'(GoodCnt), 64'd0);
        chk("s5_rst_err", 64'(ErrCnt), 64'd0);
`endif

        // Enable dropped in WAIT_WORD discards a concurrent word
        tick();
        chk("s6_wait", 64'(RxEnable), 64'd1);
        Enable = 1'b0;
        RxData = 32'h0000_0055;
        RxDone = 1'b1;
        tick();
        RxDone = 1'b0;
        chk("s6_idle_rxen", 64'(RxEnable), 64'd0);
        chk("s6_no_valid", 64'(DataValid), 64'd0);
        chk("s6_dout_keep", 64'(DataOut), 64'd0);
        tick();
        chk("s6_stay_idle", 64'(RxEnable), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter size, 32, data word width in bits; matches the receiver word width.
REQ-002 Parameter MAX_RETRY, 3, resend requests allowed per word before abort.
REQ-003 Parameter TIMEOUT, 64, baud cycles to wait for a word before it counts as a failed word.
REQ-004 CLK_Baudin  in  1  baud clock; the single clock of the block.
REQ-005 RstRx  in  1  synchronous, active-high reset.
REQ-006 Enable  in  1  level; 1 = controller runs receive sessions.
REQ-007 RxData  in  size  word from the receiver; valid only with RxDone.
REQ-008 RxDone  in  1  one-cycle pulse; receiver finished a word with good parity.
REQ-009 RxParityErr  in  1  one-cycle pulse; receiver detected a parity mismatch.
REQ-010 RxEnable  out  1  permits the receiver to hunt for a start bit.
REQ-011 ResendReq  out  1  one-cycle pulse asking the sender to retransmit.
REQ-012 DataOut  out  size  accepted word.
REQ-013 DataValid  out  1  DataOut holds a word not yet taken.
REQ-014 DataReady  in  1  consumer takes DataOut when DataValid and DataReady are both 1.
REQ-015 ErrAbort  out  1  one-cycle pulse; word dropped after retries were exhausted.
REQ-016 RetryCount  out  clog2(MAX_RETRY+1)  resends issued for the current word.

Function
REQ-017 The FSM SHALL have the states IDLE, WAIT_WORD, RESEND, HOLD and ABORT; all outputs are registered.
REQ-018 IDLE: RxEnable=0, timer=0, RetryCount=0; if Enable=1, go to WAIT_WORD on the next edge.
REQ-019 WAIT_WORD: RxEnable=1 and the timer increments every cycle.
REQ-020 WAIT_WORD, RxDone=1 and RxParityErr=0: capture RxData into DataOut, set DataValid=1, go to HOLD.
REQ-021 WAIT_WORD, failure (RxParityErr=1, or timer==TIMEOUT-1): if RetryCount<MAX_RETRY, increment RetryCount and go to RESEND; otherwise go to ABORT.
REQ-022 RxDone and RxParityErr in the same cycle SHALL be treated as a failure; DataOut is not updated.
REQ-023 RESEND: ResendReq=1 for exactly one cycle, timer cleared, return to WAIT_WORD.
REQ-024 HOLD: RxEnable=0 and DataOut stable; on DataReady=1, clear DataValid and RetryCount, then go to WAIT_WORD if Enable=1, else IDLE.
REQ-025 HOLD with DataReady held at 0 SHALL wait indefinitely; the timer is frozen.
REQ-026 ABORT: ErrAbort=1 for one cycle, RetryCount cleared, go to IDLE; DataValid stays 0.
REQ-027 Enable falling in WAIT_WORD or RESEND SHALL go to IDLE on the next edge, discarding any in-flight word; in HOLD, the handshake completes first.
REQ-028 The timer SHALL be clog2(TIMEOUT) bits wide and SHALL NOT wrap; it is cleared on entry to WAIT_WORD.
REQ-029 Minimum latency from RxDone to DataValid SHALL be 1 cycle.

Reset
REQ-030 When RstRx=1 at a clock edge: state=IDLE; RxEnable, ResendReq, DataValid, ErrAbort = 0; DataOut=0; RetryCount=0; timer=0.
REQ-031 Reset SHALL override every state, including HOLD with a pending word; that word is lost.

Configuration
REQ-032 When UART_RX_CTRL_STATS_EN is defined:
- 16-bit outputs GoodCnt and ErrCnt are added.
- GoodCnt increments on each completed handshake.
- ErrCnt increments on each failure of REQ-021.
- Both counters saturate at 0xFFFF and clear on reset.
REQ-033 When UART_RX_CTRL_STATS_EN is undefined, the counter ports and logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-034 The state encoding and the default size/MAX_RETRY/TIMEOUT constants SHALL live in the shared package uart_pkg.
REQ-035 The timeout counter SHALL be a sub-module, rx_timeout_timer, with inputs clear and run and output expired.

Verification
REQ-036 Scenario: reset, Enable=1, RxDone with RxData=0xA5A5_5A5A, DataReady=1 -> DataValid one cycle later, DataOut=0xA5A5_5A5A, return to WAIT_WORD.
REQ-037 Scenario: two RxParityErr pulses, then RxDone with 0x1234_5678 -> two single-cycle ResendReq pulses, RetryCount=2, then the word delivered and RetryCount=0.
REQ-038 Scenario: MAX_RETRY=3, four consecutive parity errors -> three ResendReq pulses, one ErrAbort pulse, state IDLE, DataValid never set.
REQ-039 Scenario: no RxDone for 64 cycles -> ResendReq on timeout; RxDone and RxParityErr together -> failure path, DataOut unchanged.
REQ-040 Scenario: word in HOLD with DataReady=0 for 100 cycles, then RstRx=1 -> DataValid stays 1 and RxEnable stays 0 until reset, then all outputs zero; with STATS_EN, GoodCnt=0.
